ram_bist: RTL and testbench

RAM_BIST -- requirements
Module: ram_bist

---
 rtl/ram_bist.sv | 182 ++++++++++++++++++
 tb/tb_ram_bist.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist.sv
// ram_bist: single-pass March-style memory BIST.
// The RAM is filled with pattern XOR address, read back in ascending order,
// and each read word is checked against the same expected value one cycle
// later, when the RAM's registered output becomes valid. All outputs are
// registered and computed from next-state values.
module ram_bist #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pattern,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [ADDR_WIDTH:0]   err_count
);

    // Number of address bits that reach the data word when forming exp(a).
    localparam int XW = (ADDR_WIDTH < DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pat_q, pat_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [ADDR_WIDTH:0]   err_count_q, err_count_d;
    // Compare pipeline: the read address issued last cycle, and whether one was issued.
    logic                  cmp_valid_q, cmp_valid_d;
    logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
    logic                  mismatch;
    logic                  addr_last;

    // Expected RAM content: seed XOR address (zero-extended or truncated).
    function automatic logic [DATA_WIDTH-1:0] exp_word(
        input logic [DATA_WIDTH-1:0] p,
        input logic [ADDR_WIDTH-1:0] a
    );
        logic [DATA_WIDTH-1:0] ax;
        ax = '0;
        for (int i = 0; i < XW; i++) begin
            ax[i] = a[i];
        end
        return p ^ ax;
    endfunction

    assign addr_last = &mem_addr_q;
    assign mismatch  = cmp_valid_q && (mem_dout != exp_word(pat_q, cmp_addr_q));

    // Next-state, next-output and result bookkeeping.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_din_d   = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        err_count_d = err_count_q;
        cmp_valid_d = 1'b0;
        cmp_addr_d  = mem_addr_q;

        // Result update for the word read back in the previous cycle.
        if (mismatch) begin
            err_count_d = err_count_q + 1'b1;
            if (err_count_q == '0) begin
                fail_addr_d = cmp_addr_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WRITE;
                    pat_d       = pattern;
                    err_count_d = '0;
                    fail_addr_d = '0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = '0;
                    mem_din_d   = exp_word(pattern, '0);
                end
            end
            S_WRITE: begin
                busy_d = 1'b1;
                if (addr_last) begin
                    // Wrap straight into the read sweep at address 0.
                    state_d    = S_READ;
                    mem_addr_d = '0;
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = mem_addr_q + 1'b1;
                    mem_din_d  = exp_word(pat_q, mem_addr_q + 1'b1);
                end
            end
            S_READ: begin
                busy_d      = 1'b1;
                cmp_valid_d = 1'b1;
                if (addr_last) begin
                    state_d    = S_DRAIN;
                    mem_addr_d = '0;
                end else begin
                    mem_addr_d = mem_addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Last read word is compared here; the verdict includes it.
                state_d = S_DONE;
                done_d  = 1'b1;
                pass_d  = (err_count_d == '0);
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset forces IDLE immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pat_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            err_count_q <= '0;
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            err_count_q <= err_count_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_addr_q  <= cmp_addr_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: directed checks of ram_bist against a behavioural RAM with
// selectable faults. Cycle k = the k-th cycle after the edge that accepts start.
module tb_ram_bist;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] pattern;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_addr;
    logic [4:0] err_count;

    int vectors;
    int miscompares;
    int fault_mode;   // 0 good, 1 addr4 bit0 stuck-at-1, 2 writes to 2 and 9 lost
    int done_cnt;
    logic [7:0] wr2_data;
    logic [7:0] mem [16];

    ram_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM with registered read and fault injection.
    always @(posedge clk) begin
        if (mem_we && !(fault_mode == 2 && (mem_addr == 4'd2 || mem_addr == 4'd9)))
            mem[mem_addr] <= mem_din;
        if (mem_we && mem_addr == 4'd2)
            wr2_data <= mem_din;
        if (fault_mode == 2 && (mem_addr == 4'd2 || mem_addr == 4'd9))
            mem_dout <= 8'hFF;
        else if (fault_mode == 1 && mem_addr == 4'd4)
            mem_dout <= mem[mem_addr] | 8'h01;
        else
            mem_dout <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: pulse start for one cycle, follow the sweep, check the verdict.
    task automatic run_test(input string tag, input logic [7:0] pat, input int mode,
                            input logic exp_pass, input logic [4:0] exp_err,
                            input logic [3:0] exp_fail);
        int seq_bad;
        int done_k;
        seq_bad = 0;
        done_k  = -1;
        fault_mode = mode;
        pattern = pat;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (k == 0) begin
                check({tag, " cleared err_count"}, 32'(err_count), 32'd0);
                check({tag, " cleared fail_addr"}, 32'(fail_addr), 32'd0);
                check({tag, " cleared pass"}, 32'(pass), 32'd0);
            end
            if (k < 16) begin
                if (mem_we !== 1'b1 || mem_addr !== 4'(k) || mem_din !== (pat ^ 8'(k)) || busy !== 1'b1)
                    seq_bad++;
            end else if (k < 32) begin
                if (mem_we !== 1'b0 || mem_addr !== 4'(k - 16) || busy !== 1'b1)
                    seq_bad++;
            end else if (k == 32) begin
                if (mem_we !== 1'b0 || mem_addr !== 4'd0 || mem_din !== 8'd0 || busy !== 1'b1)
                    seq_bad++;
            end
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
            @(negedge clk);
        end
        check({tag, " done cycle"}, 32'(done_k), 32'd33);
        check({tag, " sweep sequence errors"}, 32'(seq_bad), 32'd0);
        check({tag, " pass"}, 32'(pass), 32'(exp_pass));
        check({tag, " err_count"}, 32'(err_count), 32'(exp_err));
        check({tag, " fail_addr"}, 32'(fail_addr), 32'(exp_fail));
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(done), 32'd0);
        check({tag, " pass held"}, 32'(pass), 32'(exp_pass));
        $display("test %s pattern=%02h: pass=%0d err_count=%0d fail_addr=%0d done at k=%0d",
                 tag, pat, pass, err_count, fail_addr, done_k);
    endtask

    initial begin
        int dc0;
        int k2;
        vectors     = 0;
        miscompares = 0;
        fault_mode  = 0;
        done_cnt    = 0;
        wr2_data    = 8'h00;
        rst_n       = 1'b0;
        start       = 1'b0;
        pattern     = 8'h00;

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst mem_din", 32'(mem_din), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst pass", 32'(pass), 32'd0);
        check("rst fail_addr", 32'(fail_addr), 32'd0);
        check("rst err_count", 32'(err_count), 32'd0);

        // Good RAM, start on the very first edge after release.
        rst_n = 1'b1;
        run_test("good_AA", 8'hAA, 0, 1'b1, 5'd0, 4'd0);
        check("good_AA addr2 write data", 32'(wr2_data), 32'hA8);

        // Stuck-at-1 on bit 0 of address 4.
        run_test("stuck4", 8'h00, 1, 1'b0, 5'd1, 4'd4);

        // Lost writes at 2 and 9.
        run_test("lost2_9", 8'h55, 2, 1'b0, 5'd2, 4'd2);

        // Back-to-back good tests; results from the faulty run must be cleared.
        run_test("b2b_AA", 8'hAA, 0, 1'b1, 5'd0, 4'd0);
        run_test("b2b_55", 8'h55, 0, 1'b1, 5'd0, 4'd0);

        // start held high for 40 cycles.
        fault_mode = 0;
        pattern = 8'hAA;
        start = 1'b1;
        dc0 = done_cnt;
        k2 = 0;
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            if (k < 33 && (busy !== 1'b1 || done !== 1'b0)) k2++;
            if (k == 33) check("held done at 33", 32'(done), 32'd1);
            if (k == 34) check("held idle after done", 32'(busy), 32'd0);
            if (k == 35) check("held restart busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        start = 1'b0;
        check("held no restart mid-test", 32'(k2), 32'd0);
        check("held single done in window", 32'(done_cnt - dc0), 32'd1);
        // Second test was accepted at the edge opening cycle 35; done at 35+33.
        k2 = -1;
        for (int k = 40; k < 100; k++) begin
            if (done === 1'b1) begin
                k2 = k;
                break;
            end
            @(negedge clk);
        end
        check("held second done cycle", 32'(k2), 32'd68);
        check("held second pass", 32'(pass), 32'd1);
        $display("test held_start: second done at k=%0d pass=%0d", k2, pass);
        @(negedge clk);

        // Reset in the 5th WRITE cycle.
        pattern = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid we before", 32'(mem_we), 32'd1);
        dc0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("rstmid mem_we", 32'(mem_we), 32'd0);
        check("rstmid busy", 32'(busy), 32'd0);
        check("rstmid mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rstmid no done", 32'(done_cnt - dc0), 32'd0);
        check("rstmid stays idle", 32'(busy), 32'd0);
        check("rstmid pass", 32'(pass), 32'd0);
        $display("test rst_mid_write: no result reported after reset");
        run_test("restart_3C", 8'h3C, 0, 1'b1, 5'd0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
